// File: rtl/signal_conflict_monitor.sv
// signal_conflict_monitor
//   Independent safety checker placed between the intersection controller and
//   the lamp drivers. Watches the eight lamp codes every clock, latches the
//   first sequencing/compatibility fault it sees and holds the intersection in
//   flash until an operator clear is accepted with all lamps red.
//
// Ports
//   clk_in      system clock
//   reset       asynchronous active-low reset
//   lamps       2 bits per movement (0..7 = es ws el wl ns nl ss sl);
//               00 red, 01 green, 10 yellow, 11 invalid
//   wd_kick     controller heartbeat pulse
//   fault_clr   operator clear request (single-cycle pulse)
//   flash_en    forces lamp drivers into flash
//   fault       latched fault flag
//   fault_code  0 none, 1 conflict, 2 invalid, 3 short yellow,
//               4 skipped yellow, 5 clearance, 6 watchdog
//   fault_mov   lowest-index offending movement (0 for watchdog)
//   mon_active  high only while monitoring
//
// state    | meaning
// ---------+-----------------------------------------------------------
// STARTUP  | forced flash for STARTUP_CYCLES edges, history primes
// MONITOR  | all checks active, lamps pass through
// FAULT    | fault latched, flash, waiting for clear with all-red lamps
// RECOVER  | flash, needs STARTUP_CYCLES consecutive all-red edges

module signal_conflict_monitor #(
   parameter logic [63:0] COMPAT         = 64'hE0D0B0700E0D0B07,
   parameter int unsigned FILTER         = 2,
   parameter int unsigned MIN_YELLOW     = 2,
   parameter int unsigned MIN_RED        = 1,
   parameter int unsigned WD_TIMEOUT     = 1000,
   parameter int unsigned STARTUP_CYCLES = 8
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [15:0] lamps,
   input  logic        wd_kick,
   input  logic        fault_clr,
   output logic        flash_en,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic [2:0]  fault_mov,
   output logic        mon_active
);

   localparam int TMR_W = $clog2(STARTUP_CYCLES + 1);
   localparam int WD_W  = $clog2(WD_TIMEOUT + 1);
   localparam int YC_W  = $clog2(MIN_YELLOW + 1);
   localparam int RA_W  = $clog2(MIN_RED + 1);

   localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(STARTUP_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_INIT  = WD_W'(WD_TIMEOUT);
   localparam logic [YC_W-1:0]  YC_MAX   = YC_W'(MIN_YELLOW);
   localparam logic [RA_W-1:0]  RA_MAX   = RA_W'(MIN_RED);
   localparam logic [2:0]       FLT_LAST = 3'(FILTER - 1);

   typedef enum logic [1:0] {ST_STARTUP, ST_MONITOR, ST_FAULT, ST_RECOVER} state_t;

   state_t state, state_nxt;

   logic [1:0]       cur       [8];
   logic [1:0]       prev_code [8];
   logic [YC_W-1:0]  ycnt      [8];
   logic [RA_W-1:0]  rage      [8];
   logic [TMR_W-1:0] tmr;
   logic [WD_W-1:0]  wd_cnt;
   logic [2:0]       conf_cnt, inv_cnt;

   logic       conf_any, inv_any, sy_any, sk_any, cl_any;
   logic [2:0] conf_mov, inv_mov, sy_mov, sk_mov, cl_mov;
   logic       conf_hit, inv_hit, wd_hit, det;
   logic [2:0] det_code, det_mov;
   logic       all_red;

   assign all_red = (lamps == 16'h0000);

   // Checks use the sampled lamps against pre-update history. Loops run from
   // the top index down so the lowest offending movement is the one kept.
   always_comb begin
      conf_any = 1'b0; conf_mov = 3'd0;
      inv_any  = 1'b0; inv_mov  = 3'd0;
      sy_any   = 1'b0; sy_mov   = 3'd0;
      sk_any   = 1'b0; sk_mov   = 3'd0;
      cl_any   = 1'b0; cl_mov   = 3'd0;
      for (int i = 0; i < 8; i++) cur[i] = lamps[2*i +: 2];
      for (int i = 7; i >= 0; i--) begin
         for (int j = 0; j < 8; j++) begin
            if (i != j && cur[i] != 2'b00 && cur[j] != 2'b00 && !COMPAT[i*8+j]) begin
               conf_any = 1'b1;
               conf_mov = 3'(i);
            end
            if (i != j && prev_code[i] == 2'b00 && cur[i] == 2'b01 &&
                !COMPAT[i*8+j] && rage[j] < RA_MAX) begin
               cl_any = 1'b1;
               cl_mov = 3'(i);
            end
         end
         if (cur[i] == 2'b11) begin
            inv_any = 1'b1;
            inv_mov = 3'(i);
         end
         if (prev_code[i] == 2'b10 && cur[i] == 2'b00 && ycnt[i] < YC_MAX) begin
            sy_any = 1'b1;
            sy_mov = 3'(i);
         end
         if (prev_code[i] == 2'b01 && cur[i] == 2'b00) begin
            sk_any = 1'b1;
            sk_mov = 3'(i);
         end
      end
   end

   assign conf_hit = conf_any && (conf_cnt == FLT_LAST);
   assign inv_hit  = inv_any && (inv_cnt == FLT_LAST);
   // A kick on the terminal edge wins over the timeout.
   assign wd_hit   = !wd_kick && (wd_cnt == WD_W'(1));

   always_comb begin
      det      = 1'b1;
      det_code = 3'd0;
      det_mov  = 3'd0;
      if (conf_hit)     begin det_code = 3'd1; det_mov = conf_mov; end
      else if (inv_hit) begin det_code = 3'd2; det_mov = inv_mov;  end
      else if (sy_any)  begin det_code = 3'd3; det_mov = sy_mov;   end
      else if (sk_any)  begin det_code = 3'd4; det_mov = sk_mov;   end
      else if (cl_any)  begin det_code = 3'd5; det_mov = cl_mov;   end
      else if (wd_hit)  begin det_code = 3'd6; det_mov = 3'd0;     end
      else              det = 1'b0;
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) state <= ST_STARTUP;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_STARTUP: if (tmr == '0) state_nxt = ST_MONITOR;
         ST_MONITOR: if (det) state_nxt = ST_FAULT;
         ST_FAULT:   if (fault_clr && all_red) state_nxt = ST_RECOVER;
         ST_RECOVER: if (all_red && tmr == '0) state_nxt = ST_MONITOR;
         default:    state_nxt = ST_STARTUP;
      endcase
   end

   always_comb begin
      flash_en   = (state != ST_MONITOR);
      mon_active = (state == ST_MONITOR);
      fault      = (state == ST_FAULT) || (state == ST_RECOVER);
   end

   // Startup/recover down-counter and watchdog down-counter.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         tmr    <= TMR_INIT;
         wd_cnt <= WD_INIT;
      end else begin
         case (state)
            ST_STARTUP: if (tmr != '0) tmr <= tmr - TMR_W'(1);
            ST_RECOVER: begin
               if (!all_red)       tmr <= TMR_INIT;
               else if (tmr != '0) tmr <= tmr - TMR_W'(1);
            end
            default:    tmr <= TMR_INIT;
         endcase
         if (state == ST_MONITOR && !wd_kick) wd_cnt <= wd_cnt - WD_W'(1);
         else                                 wd_cnt <= WD_INIT;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         conf_cnt <= 3'd0;
         inv_cnt  <= 3'd0;
      end else if (state == ST_MONITOR) begin
         conf_cnt <= conf_any ? conf_cnt + 3'd1 : 3'd0;
         inv_cnt  <= inv_any  ? inv_cnt  + 3'd1 : 3'd0;
      end else begin
         conf_cnt <= 3'd0;
         inv_cnt  <= 3'd0;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         fault_code <= 3'd0;
         fault_mov  <= 3'd0;
      end else if (state == ST_MONITOR && det) begin
         fault_code <= det_code;
         fault_mov  <= det_mov;
      end else if (state == ST_RECOVER && state_nxt == ST_MONITOR) begin
         fault_code <= 3'd0;
         fault_mov  <= 3'd0;
      end
   end

   // History runs in every state so it is current when monitoring resumes.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            prev_code[i] <= 2'b00;
            ycnt[i]      <= '0;
            rage[i]      <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            prev_code[i] <= cur[i];
            if (cur[i] == 2'b10) ycnt[i] <= (ycnt[i] == YC_MAX) ? ycnt[i] : ycnt[i] + YC_W'(1);
            else                 ycnt[i] <= '0;
            if (cur[i] == 2'b00) rage[i] <= (rage[i] == RA_MAX) ? rage[i] : rage[i] + RA_W'(1);
            else                 rage[i] <= '0;
         end
      end
   end

endmodule
